// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared constants for the pe_acc dot-product accumulator.
//                Lane count and widths of products, result and the
//                intermediate adder-tree sums, plus int32 range limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;
    localparam int LANES         = 32;
    localparam int PROD_W        = 32;
    localparam int OUT_W         = 32;
    localparam int ACC_W_DEFAULT = 48;

    // Adder tree shape: groups of 4 lanes, then a sum of the 8 group sums.
    localparam int GROUPS = LANES / 4;
    localparam int S1_W   = PROD_W + 2;
    localparam int S2_W   = S1_W + 3;

    localparam logic signed [OUT_W-1:0] INT32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [OUT_W-1:0] INT32_MIN = 32'sh8000_0000;
endpackage
`default_nettype wire

// File: rtl/pe_add4.sv
`default_nettype none
// ============================================================================
//  Module      : pe_add4
//  Description : Combinational signed adder of four int32 values producing a
//                34-bit result that cannot overflow.
//  Ports       : i_a..i_d  - signed 32-bit operands
//                o_sum     - signed 34-bit sum
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_add4
    import pe_pkg::*;
(
    input  logic signed [PROD_W-1:0] i_a,
    input  logic signed [PROD_W-1:0] i_b,
    input  logic signed [PROD_W-1:0] i_c,
    input  logic signed [PROD_W-1:0] i_d,
    output logic signed [S1_W-1:0]   o_sum
);
    always_comb begin
        o_sum = {{2{i_a[PROD_W-1]}}, i_a} + {{2{i_b[PROD_W-1]}}, i_b}
              + {{2{i_c[PROD_W-1]}}, i_c} + {{2{i_d[PROD_W-1]}}, i_d};
    end
endmodule
`default_nettype wire

// File: rtl/pe_acc.sv
`default_nettype none
// ============================================================================
//  Module      : pe_acc
//  Description : Three-stage pipelined dot-product accumulator. Each beat
//                carries 32 signed int32 products; beats are reduced by an
//                adder tree (S1: 8 x 4-lane sums, S2: total) and accumulated
//                (S3) until the beat flagged last, which emits an int32
//                result and an overflow flag.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready/in_data[1023:0]/in_last  - beat input
//                out_valid/out_ready/out_data[31:0]/out_ovf - group result
//  Config      : PE_ACC_SAT_EN - when defined, out_data saturates to the
//                int32 range; otherwise it is the low 32 bits (wrap).
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_acc
    import pe_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*PROD_W-1:0]   in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_ovf
);
    localparam logic signed [ACC_W-1:0] c_acc_max = ACC_W'(INT32_MAX);
    localparam logic signed [ACC_W-1:0] c_acc_min = ACC_W'(INT32_MIN);

    logic                    w_stall;
    logic signed [S1_W-1:0]  w_s1_sum [GROUPS];
    logic signed [S2_W-1:0]  w_s2_sum;
    logic signed [ACC_W-1:0] w_acc_base;
    logic signed [ACC_W-1:0] w_acc_new;
    logic                    w_ovf;
    logic [OUT_W-1:0]        w_res_data;

    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic signed [S1_W-1:0]  r_s1_sum [GROUPS];
    logic                    r_s2_valid;
    logic                    r_s2_last;
    logic signed [S2_W-1:0]  r_s2_sum;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_first;
    logic                    r_out_valid;
    logic [OUT_W-1:0]        r_out_data;
    logic                    r_out_ovf;

    // The whole pipeline freezes only when a finished result is waiting.
    assign w_stall   = r_out_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

    generate
        for (genvar g = 0; g < GROUPS; g++) begin : g_s1
            pe_add4 u_add4 (
                .i_a   (in_data[(4*g+0)*PROD_W +: PROD_W]),
                .i_b   (in_data[(4*g+1)*PROD_W +: PROD_W]),
                .i_c   (in_data[(4*g+2)*PROD_W +: PROD_W]),
                .i_d   (in_data[(4*g+3)*PROD_W +: PROD_W]),
                .o_sum (w_s1_sum[g])
            );
        end
    endgenerate

    always_comb begin
        w_s2_sum = '0;
        for (int k = 0; k < GROUPS; k++) begin
            w_s2_sum = w_s2_sum + {{(S2_W-S1_W){r_s1_sum[k][S1_W-1]}}, r_s1_sum[k]};
        end
    end

    always_comb begin
        // A new group starts from zero instead of the previous total.
        w_acc_base = r_first ? '0 : r_acc;
        w_acc_new  = w_acc_base + ACC_W'(r_s2_sum);
        w_ovf      = (w_acc_new > c_acc_max) || (w_acc_new < c_acc_min);
`ifdef PE_ACC_SAT_EN
        if (w_ovf) begin
            w_res_data = w_acc_new[ACC_W-1] ? INT32_MIN : INT32_MAX;
        end else begin
            w_res_data = w_acc_new[OUT_W-1:0];
        end
`else
        w_res_data = w_acc_new[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            for (int k = 0; k < GROUPS; k++) begin
                r_s1_sum[k] <= '0;
            end
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_sum    <= '0;
            r_acc       <= '0;
            r_first     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (!w_stall) begin
            // in_ready is 1 here, so in_valid alone marks an accepted beat.
            r_s1_valid <= in_valid;
            r_s1_last  <= in_last;
            r_s1_sum   <= w_s1_sum;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_sum   <= w_s2_sum;
            if (r_s2_valid) begin
                r_acc   <= w_acc_new;
                r_first <= r_s2_last;
            end
            // Not stalled: any pending result is being taken this edge, so a
            // new result may replace it directly.
            if (r_s2_valid && r_s2_last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res_data;
                r_out_ovf   <= w_ovf;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire
